// File: rtl/ram_bist_pkg.sv
// Shared types and pattern generator for the RAM self-test engine.
package ram_bist_pkg;

    localparam int unsigned PAT_W = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        VERIFY = 2'd2,
        DRAIN  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        MODE_INCR    = 2'd0,
        MODE_CHECKER = 2'd1,
        MODE_WALK1   = 2'd2,
        MODE_SOLID   = 2'd3
    } mode_e;

    // Pattern word for (mode, address, pass), computed at full width and masked to data_w bits.
    function automatic logic [PAT_W-1:0] gen_pattern(
        input mode_e             mode,
        input logic [PAT_W-1:0]  addr,
        input logic [PAT_W-1:0]  pass,
        input int unsigned       data_w
    );
        logic [PAT_W-1:0] mask;
        logic [PAT_W-1:0] alt01;
        logic [PAT_W-1:0] pat;
        mask  = (data_w >= PAT_W) ? '1 : ((PAT_W'(1) << data_w) - PAT_W'(1));
        alt01 = {(PAT_W/2){2'b01}};
        pat   = '0;
        case (mode)
            MODE_INCR:    pat = addr + pass;
            MODE_CHECKER: pat = (addr[0] ^ pass[0]) ? ~alt01 : alt01;
            MODE_WALK1:   pat = PAT_W'(1) << (addr % PAT_W'(data_w));
            MODE_SOLID:   pat = pass[0] ? '1 : '0;
            default:      pat = '0;
        endcase
        return pat & mask;
    endfunction

endpackage

// File: rtl/ram_bist_sp_ram.sv
// Single-port synchronous RAM with registered read data; contents are not reset.
module ram_bist_sp_ram #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_addr] <= i_wdata;
        end
        rdata_q <= mem[i_addr];
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/ram_bist_engine.sv
// RAM self-test engine: fill/verify/drain passes with statistics.
// Optional `RAM_BIST_FAULT_INJECT_EN adds i_fault_inject to flip bit 0 of written words.
module ram_bist_engine
    import ram_bist_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start_system,
    input  logic              i_stop_system,
    input  logic [1:0]        i_mode,
`ifdef RAM_BIST_FAULT_INJECT_EN
    input  logic              i_fault_inject,
`endif
    output logic              o_busy,
    output logic              o_pass_done,
    output logic [CNT_W-1:0]  data_sets_generated,
    output logic [CNT_W-1:0]  data_sets_matched,
    output logic [CNT_W-1:0]  o_mismatch_count,
    output logic [CNT_W-1:0]  o_pass_count,
    output logic [ADDR_W-1:0] o_first_fail_addr,
    output logic              o_fail_seen
);

    state_e            state_q, state_d;
    mode_e             mode_q, mode_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;
    logic              cmp_valid_q, cmp_valid_d;
    logic [DATA_W-1:0] pass_idx_q, pass_idx_d;
    logic              stop_pend_q, stop_pend_d;
    logic              busy_q, busy_d;
    logic              pass_done_q, pass_done_d;
    logic [CNT_W-1:0]  gen_q, gen_d;
    logic [CNT_W-1:0]  match_q, match_d;
    logic [CNT_W-1:0]  mism_q, mism_d;
    logic [CNT_W-1:0]  pass_cnt_q, pass_cnt_d;
    logic [ADDR_W-1:0] ffa_q, ffa_d;
    logic              fail_q, fail_d;

    logic              ram_we;
    logic              fault;
    logic [DATA_W-1:0] wr_pat;
    logic [DATA_W-1:0] exp_pat;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

`ifdef RAM_BIST_FAULT_INJECT_EN
    assign fault = i_fault_inject;
`else
    assign fault = 1'b0;
`endif

    assign wr_pat    = DATA_W'(gen_pattern(mode_q, PAT_W'(addr_q), PAT_W'(pass_idx_q), DATA_W));
    assign exp_pat   = DATA_W'(gen_pattern(mode_q, PAT_W'(cmp_addr_q), PAT_W'(pass_idx_q), DATA_W));
    assign ram_wdata = wr_pat ^ {{(DATA_W-1){1'b0}}, fault};

    ram_bist_sp_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (ram_we),
        .i_addr  (addr_q),
        .i_wdata (ram_wdata),
        .o_rdata (ram_rdata)
    );

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        addr_d      = addr_q;
        cmp_addr_d  = addr_q;
        cmp_valid_d = (state_q == VERIFY);
        pass_idx_d  = pass_idx_q;
        stop_pend_d = stop_pend_q;
        pass_done_d = 1'b0;
        gen_d       = gen_q;
        match_d     = match_q;
        mism_d      = mism_q;
        pass_cnt_d  = pass_cnt_q;
        ffa_d       = ffa_q;
        fail_d      = fail_q;
        ram_we      = 1'b0;

        // Compare the word whose read was issued in the previous cycle.
        if (cmp_valid_q) begin
            if (ram_rdata == exp_pat) begin
                match_d = sat_inc(match_q);
            end else begin
                mism_d = sat_inc(mism_q);
                if (!fail_q) begin
                    fail_d = 1'b1;
                    ffa_d  = cmp_addr_q;
                end
            end
        end

        if (state_q != IDLE && i_stop_system) begin
            stop_pend_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (i_start_system && !i_stop_system) begin
                    state_d     = FILL;
                    mode_d      = mode_e'(i_mode);
                    addr_d      = '0;
                    pass_idx_d  = '0;
                    stop_pend_d = 1'b0;
                    gen_d       = '0;
                    match_d     = '0;
                    mism_d      = '0;
                    pass_cnt_d  = '0;
                    ffa_d       = '0;
                    fail_d      = 1'b0;
                end
            end
            FILL: begin
                ram_we = 1'b1;
                gen_d  = sat_inc(gen_q);
                addr_d = addr_q + ADDR_W'(1);
                if (addr_q == '1) begin
                    state_d = VERIFY;
                end
            end
            VERIFY: begin
                addr_d = addr_q + ADDR_W'(1);
                if (addr_q == '1) begin
                    state_d     = DRAIN;
                    pass_done_d = 1'b1;
                end
            end
            DRAIN: begin
                pass_cnt_d = sat_inc(pass_cnt_q);
                pass_idx_d = pass_idx_q + DATA_W'(1);
                if (stop_pend_q || i_stop_system) begin
                    state_d     = IDLE;
                    stop_pend_d = 1'b0;
                end else begin
                    state_d = FILL;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            mode_q      <= MODE_INCR;
            addr_q      <= '0;
            cmp_addr_q  <= '0;
            cmp_valid_q <= 1'b0;
            pass_idx_q  <= '0;
            stop_pend_q <= 1'b0;
            busy_q      <= 1'b0;
            pass_done_q <= 1'b0;
            gen_q       <= '0;
            match_q     <= '0;
            mism_q      <= '0;
            pass_cnt_q  <= '0;
            ffa_q       <= '0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            addr_q      <= addr_d;
            cmp_addr_q  <= cmp_addr_d;
            cmp_valid_q <= cmp_valid_d;
            pass_idx_q  <= pass_idx_d;
            stop_pend_q <= stop_pend_d;
            busy_q      <= busy_d;
            pass_done_q <= pass_done_d;
            gen_q       <= gen_d;
            match_q     <= match_d;
            mism_q      <= mism_d;
            pass_cnt_q  <= pass_cnt_d;
            ffa_q       <= ffa_d;
            fail_q      <= fail_d;
        end
    end

    assign o_busy              = busy_q;
    assign o_pass_done         = pass_done_q;
    assign data_sets_generated = gen_q;
    assign data_sets_matched   = match_q;
    assign o_mismatch_count    = mism_q;
    assign o_pass_count        = pass_cnt_q;
    assign o_first_fail_addr   = ffa_q;
    assign o_fail_seen         = fail_q;

endmodule

// File: tb/tb_ram_bist_engine.sv
// Bench for ram_bist_engine: a full-width instance and a 4-bit-counter instance share all inputs.
module tb_ram_bist_engine;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned CNT_W    = 32;
    localparam int unsigned SAT_W    = 4;
    localparam int          DEPTH    = 16;
    localparam int          PASS_LEN = 33;
    localparam int          SAT_MAX  = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start;
    logic       stop;
    logic       fault;
    logic [1:0] mode;

    logic              busy, pass_done, fail_seen;
    logic [CNT_W-1:0]  gen, match, mism, passes;
    logic [ADDR_W-1:0] ffa;

    logic              s_busy, s_pass_done, s_fail_seen;
    logic [SAT_W-1:0]  s_gen, s_match, s_mism, s_passes;
    logic [ADDR_W-1:0] s_ffa;

    ram_bist_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_dut (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .i_start_system      (start),
        .i_stop_system       (stop),
        .i_mode              (mode),
`ifdef RAM_BIST_FAULT_INJECT_EN
        .i_fault_inject      (fault),
`endif
        .o_busy              (busy),
        .o_pass_done         (pass_done),
        .data_sets_generated (gen),
        .data_sets_matched   (match),
        .o_mismatch_count    (mism),
        .o_pass_count        (passes),
        .o_first_fail_addr   (ffa),
        .o_fail_seen         (fail_seen)
    );

    ram_bist_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(SAT_W)) u_sat (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .i_start_system      (start),
        .i_stop_system       (stop),
        .i_mode              (mode),
`ifdef RAM_BIST_FAULT_INJECT_EN
        .i_fault_inject      (fault),
`endif
        .o_busy              (s_busy),
        .o_pass_done         (s_pass_done),
        .data_sets_generated (s_gen),
        .data_sets_matched   (s_match),
        .o_mismatch_count    (s_mism),
        .o_pass_count        (s_passes),
        .o_first_fail_addr   (s_ffa),
        .o_fail_seen         (s_fail_seen)
    );

    typedef struct {
        int gen;
        int match;
        int mism;
        int passes;
        int fail;
        int ffa;
    } exp_t;

    typedef struct {
        logic [1:0] mode;
        int         npasses;
        bit         start_mid;
        exp_t       exp;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[7];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_pat(input int m, input int a, input int p);
        logic [7:0] r;
        case (m)
            0:       r = 8'((a + p) % 256);
            1:       r = (((a ^ p) & 1) == 0) ? 8'h55 : 8'hAA;
            2:       r = 8'(1 << (a % 8));
            default: r = ((p & 1) == 1) ? 8'hFF : 8'h00;
        endcase
        return r;
    endfunction

    function automatic int sat(input int v);
        return (v > SAT_MAX) ? SAT_MAX : v;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_pass_done"}, pass_done, 0);
        check({tag, "_gen"}, gen, 0);
        check({tag, "_match"}, match, 0);
        check({tag, "_mism"}, mism, 0);
        check({tag, "_passes"}, passes, 0);
        check({tag, "_ffa"}, ffa, 0);
        check({tag, "_fail"}, fail_seen, 0);
        check({tag, "_sat_gen"}, s_gen, 0);
        check({tag, "_sat_busy"}, s_busy, 0);
    endtask

    // One run: start, optional ignored mid-run start, stop in the last pass, optional fault pulse.
    task automatic run(input logic [1:0] m, input int np, input bit start_mid,
                       input int fault_idx, input exp_t e);
        int   idx;
        int   n_done;
        bit   done;
        exp_t x;
        logic [7:0] ew;
        sb_q.push_back(e);
        @(negedge clk);
        mode  = m;
        start = 1'b1;
        idx    = 0;
        n_done = 0;
        done   = 1'b0;
        while (!done && idx < np * PASS_LEN + 20) begin
            @(negedge clk);
            idx++;
            start = 1'b0;
            stop  = 1'b0;
            fault = 1'b0;
            if (idx == 1) check("busy_after_start", busy, 1);
            if (pass_done) begin
                n_done++;
                check("pass_done_cycle", idx, n_done * PASS_LEN);
            end
            if (!busy && idx > 1) begin
                done = 1'b1;
            end else begin
                if (start_mid && idx == 3) begin
                    start = 1'b1;
                    mode  = ~m;
                end
                if (idx == (np - 1) * PASS_LEN + 5) stop = 1'b1;
                if (idx == fault_idx) fault = 1'b1;
            end
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL run_timeout: busy still %0d after %0d cycles, required 0", busy, idx);
            void'(sb_q.pop_front());
            return;
        end
        check("run_length", idx, np * PASS_LEN + 1);
        check("pass_done_count", n_done, np);
        x = sb_q.pop_front();
        check("gen", gen, x.gen);
        check("match", match, x.match);
        check("mism", mism, x.mism);
        check("passes", passes, x.passes);
        check("fail_seen", fail_seen, x.fail);
        check("first_fail_addr", ffa, x.ffa);
        check("sat_gen", s_gen, sat(x.gen));
        check("sat_match", s_match, sat(x.match));
        check("sat_mism", s_mism, sat(x.mism));
        check("sat_passes", s_passes, sat(x.passes));
        check("sat_busy", s_busy, 0);
        for (int a = 0; a < DEPTH; a++) begin
            ew = model_pat(int'(m), a, np - 1);
            if (fault_idx > 0 && (fault_idx - 1) / PASS_LEN == np - 1
                && (fault_idx - 1) % PASS_LEN == a) begin
                ew = ew ^ 8'h01;
            end
            check($sformatf("ram_word_%0d", a), u_dut.u_ram.mem[a], ew);
        end
    endtask

    initial begin
        vecs[0] = '{2'd1, 3, 1'b0, '{48, 48, 0, 3, 0, 0}};
        vecs[1] = '{2'd0, 1, 1'b0, '{16, 16, 0, 1, 0, 0}};
        vecs[2] = '{2'd2, 2, 1'b1, '{32, 32, 0, 2, 0, 0}};
        vecs[3] = '{2'd3, 1, 1'b0, '{16, 16, 0, 1, 0, 0}};
        vecs[4] = '{2'd0, 2, 1'b0, '{32, 32, 0, 2, 0, 0}};
        vecs[5] = '{2'd3, 2, 1'b0, '{32, 32, 0, 2, 0, 0}};
        vecs[6] = '{2'd1, 2, 1'b1, '{32, 32, 0, 2, 0, 0}};

        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        fault = 1'b0;
        mode  = 2'd0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Start and stop together in IDLE must not launch a run.
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("start_stop_same");

        // A lone stop in IDLE must not cut the following multi-pass run short.
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run(vecs[i].mode, vecs[i].npasses, vecs[i].start_mid, -1, vecs[i].exp);
        end

`ifdef RAM_BIST_FAULT_INJECT_EN
        run(2'd2, 2, 1'b0, PASS_LEN + 1 + 5, '{32, 31, 1, 2, 1, 5});
`endif

        // Asynchronous reset while filling address 7.
        @(negedge clk);
        mode  = 2'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        check("gen_before_reset", gen, 7);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("after_reset");
        run(2'd0, 1, 1'b0, -1, '{16, 16, 0, 1, 0, 0});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
